mat_pair_feeder: RTL and testbench
==================================

Name: mat_pair_feeder

Overview:
- Upstream operand stage for the iterative 32-lane 8-bit dot-product engine.
- Buffers operand matrices A and B (DIM x DIM, 8-bit elements), loaded as one byte stream.
- Issues every (row i of A, column j of B) pair to the engine, one at a time, and waits for the engine's result-valid before issuing the next pair.
- Exports the (i, j) index of the pair in flight so a downstream collector can place each result.

Parameters:
- DIM, 32: matrix dimension. Must equal the engine lane count (32).
- IW, 5: index width. Equals clog2(DIM).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- axiiv  input  1  load byte valid.
- axiid  input  8  load byte data. A is sent first, then B, each row-major.
- load_ready  output  1  high while in LOAD.
- row_out  output  DIM x 8  row i of A. Element k goes to lane k.
- col_out  output  DIM x 8  column j of B. Lane k carries B[k][j].
- axiov  output  1  one-cycle issue strobe; connects to the engine's axiiv.
- result_valid  input  1  the engine's axiov.
- row_idx  output  IW  i of the pair in flight.
- col_idx  output  IW  j of the pair in flight.
- busy  output  1  high in ISSUE or WAIT.
- done  output  1  one-cycle pulse after the last result is received.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - State = LOAD; load counter = 0; i = j = 0.
  - axiov = 0, done = 0, busy = 0, load_ready = 1.
  - row_out and col_out = 0.
  - Matrix storage is not cleared.
- States: LOAD, ISSUE, WAIT, DONE.
- LOAD:
  - Each cycle with axiiv = 1 writes axiid at load counter k, then k increments.
  - For k < DIM*DIM, write A[k/DIM][k%DIM]. Otherwise write B[(k-DIM*DIM)/DIM][(k-DIM*DIM)%DIM].
  - Cycles with axiiv = 0 are bubbles: no write, k unchanged.
  - The byte with k = 2*DIM*DIM-1 is written. On the same edge: state goes to ISSUE, k resets to 0, i = j = 0, load_ready drops.
- ISSUE (one cycle):
  - row_out and col_out present A[i] and column j of B.
  - Requirement: row_out, col_out, row_idx and col_idx are valid in the same cycle as axiov = 1.
  - Next state: WAIT.
- WAIT:
  - axiov = 0. row_out, col_out and the indices hold.
  - On an edge with result_valid = 1:
    - If (i, j) = (DIM-1, DIM-1), go to DONE.
    - Otherwise advance j. When j = DIM-1, j wraps to 0 and i increments. Then go to ISSUE.
  - The next axiov therefore rises the cycle after result_valid. The engine has returned to idle by then.
- DONE (one cycle): done = 1. Next state: LOAD, with load_ready = 1.
- Ignored inputs:
  - axiiv outside LOAD is ignored.
  - result_valid outside WAIT is ignored.
- There is no timeout. WAIT holds indefinitely.
- Reset mid-operation, in any state: immediate return to reset values. Any partially loaded matrix is discarded logically; a fresh 2*DIM*DIM-byte load is required.
- No arithmetic is performed on data. Counters wrap only as stated.

Optional Feature:
- Macro: B_COL_MAJOR_EN.
- When defined: the B portion of the stream is column-major, so byte k-DIM*DIM is written to B[(k-DIM*DIM)%DIM][(k-DIM*DIM)/DIM]. Issue behaviour and port semantics are unchanged.
- When undefined: B is row-major as above.

Test Plan:
- Reset check: assert rst 2 cycles -> load_ready = 1; axiov, done, busy, row_idx, col_idx = 0; row_out and col_out all 0.
- Load and first issue: stream 2048 bytes, byte k = k mod 256, no bubbles -> first axiov on the cycle after the last byte. Required values at that strobe:
  - row_out[k] = k.
  - col_out[k] = (k*32) mod 256.
  - row_idx = 0, col_idx = 0.
  - axiov high for exactly 1 cycle.
- Handshake hold: keep result_valid low 100 cycles -> no further axiov. Then pulse result_valid 1 cycle -> axiov the next cycle, with col_idx = 1 and col_out[k] = (k*32+1) mod 256.
- Full sweep against an engine model (axiov returned 34 cycles after axiiv): 1024 issues in (i, j) row-major order.
  - Check index wrap (0,31) -> (1,0).
  - done pulses once, the cycle after the 1024th result_valid is sampled.
  - Then load_ready = 1.
- Stray and bubbled inputs:
  - axiiv pulses during WAIT -> storage unchanged; later row_out is still as loaded.
  - Load with a bubble every 3rd cycle -> identical row_out and col_out to the no-bubble run.
  - result_valid pulses during LOAD -> ignored.
- Reset mid-WAIT at pair (0,5) -> next cycle state is LOAD, axiov = 0, indices = 0. A reload is required before any further axiov.

Source files
------------

// File: rtl/mat_pair_feeder_if.sv
// Operand feeder bus: byte-stream load, pair issue strobe and result handshake.
// The master modport is the feeder side; slave is the loader/engine side.
interface mat_pair_feeder_if #(
   parameter int DIM = 32,
   parameter int IW  = 5
);
   logic                   axiiv;
   logic [7:0]             axiid;
   logic                   load_ready;
   logic [DIM-1:0][7:0]    row_out;
   logic [DIM-1:0][7:0]    col_out;
   logic                   axiov;
   logic                   result_valid;
   logic [IW-1:0]          row_idx;
   logic [IW-1:0]          col_idx;
   logic                   busy;
   logic                   done;

   modport master (
      input  axiiv, axiid, result_valid,
      output load_ready, row_out, col_out, axiov,
      output row_idx, col_idx, busy, done
   );

   modport slave (
      output axiiv, axiid, result_valid,
      input  load_ready, row_out, col_out, axiov,
      input  row_idx, col_idx, busy, done
   );
endinterface

// File: rtl/mat_pair_feeder.sv
// Buffers A and B, then issues every (row i of A, column j of B) pair in turn.
// Define B_COL_MAJOR_EN when the B part of the load stream is column-major.
module mat_pair_feeder #(
   parameter int DIM = 32,
   parameter int IW  = 5
) (
   input  logic              clk,
   input  logic              rst,
   mat_pair_feeder_if.master bus
);
   localparam int KW = 2*IW + 1;

   typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DONE} state_t;

   state_t              state;
   logic [KW-1:0]       k;
   logic [IW-1:0]       i, j;
   logic [IW-1:0]       ni, nj;
   logic [IW-1:0]       sel_i, sel_j;
   logic [IW-1:0]       kr, kc;
   logic                last_byte, last_pair, wr;
   logic                axiov_q, done_q, busy_q, ready_q;
   logic [DIM-1:0][7:0] row_q, col_q;
   logic [DIM-1:0][7:0] row_nx, col_nx;
   logic [7:0]          a_mem [DIM][DIM];
   logic [7:0]          b_mem [DIM][DIM];

   assign kr        = k[2*IW-1:IW];
   assign kc        = k[IW-1:0];
   assign last_byte = (k == KW'(2*DIM*DIM - 1));
   assign last_pair = (i == IW'(DIM-1)) && (j == IW'(DIM-1));
   assign wr        = (state == LOAD) && bus.axiiv && !rst;

   assign nj = (j == IW'(DIM-1)) ? '0 : j + 1'b1;
   assign ni = (j == IW'(DIM-1)) ? i + 1'b1 : i;

   // Operands are fetched for the pair about to issue, so they
   // land in the output registers on the same edge as axiov.
   assign sel_i = (state == WAIT) ? ni : '0;
   assign sel_j = (state == WAIT) ? nj : '0;

   always_comb begin
      row_nx = '0;
      col_nx = '0;
      for (int l = 0; l < DIM; l++) begin
         row_nx[l] = a_mem[sel_i][l];
         col_nx[l] = b_mem[l][sel_j];
      end
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         if (!k[2*IW])
            a_mem[kr][kc] <= bus.axiid;
         else
`ifdef B_COL_MAJOR_EN
            b_mem[kc][kr] <= bus.axiid;
`else
            b_mem[kr][kc] <= bus.axiid;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= LOAD;
         k       <= '0;
         i       <= '0;
         j       <= '0;
         axiov_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         unique case (state)
            LOAD: begin
               if (bus.axiiv) begin
                  if (last_byte) begin
                     k       <= '0;
                     i       <= '0;
                     j       <= '0;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                     axiov_q <= 1'b1;
                     row_q   <= row_nx;
                     col_q   <= col_nx;
                     state   <= ISSUE;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            ISSUE: begin
               axiov_q <= 1'b0;
               state   <= WAIT;
            end
            WAIT: begin
               if (bus.result_valid) begin
                  if (last_pair) begin
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     i       <= ni;
                     j       <= nj;
                     row_q   <= row_nx;
                     col_q   <= col_nx;
                     axiov_q <= 1'b1;
                     state   <= ISSUE;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= LOAD;
            end
            default: state <= LOAD;
         endcase
      end
   end

   assign bus.load_ready = ready_q;
   assign bus.row_out    = row_q;
   assign bus.col_out    = col_q;
   assign bus.axiov      = axiov_q;
   assign bus.row_idx    = i;
   assign bus.col_idx    = j;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_mat_pair_feeder.sv
// Scoreboard bench for mat_pair_feeder: load, issue order, handshake,
// stray inputs, bubbled load and mid-WAIT reset.
module tb_mat_pair_feeder;
   localparam int DIM = 32;
   localparam int IW  = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mat_pair_feeder_if #(.DIM(DIM), .IW(IW)) bus ();

   mat_pair_feeder #(.DIM(DIM), .IW(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int i;
      int j;
   } pair_t;

   pair_t    sb [$];
   int       n_chk = 0;
   int       n_err = 0;
   bit [7:0] ma [DIM][DIM];
   bit [7:0] mb [DIM][DIM];

   task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] exp_row(int r);
      logic [255:0] v = '0;
      for (int l = 0; l < DIM; l++) v[l*8 +: 8] = ma[r][l];
      return v;
   endfunction

   function automatic logic [255:0] exp_col(int c);
      logic [255:0] v = '0;
      for (int l = 0; l < DIM; l++) v[l*8 +: 8] = mb[l][c];
      return v;
   endfunction

   task automatic push(int pi, int pj);
      pair_t e;
      e.i = pi;
      e.j = pj;
      sb.push_back(e);
   endtask

   // Byte stream k mod 256; a bubble every 'gap' cycles when gap > 0.
   task automatic load(int gap);
      int cyc = 0;
      int kk = 0;
      while (kk < 2*DIM*DIM) begin
         @(negedge clk);
         cyc++;
         if (gap > 0 && (cyc % gap) == 0) begin
            bus.axiiv = 1'b0;
            bus.axiid = 8'hEE;
         end else begin
            bus.axiiv = 1'b1;
            bus.axiid = 8'(kk);
            if (kk < DIM*DIM)
               ma[kk/DIM][kk%DIM] = 8'(kk);
            else
`ifdef B_COL_MAJOR_EN
               mb[(kk-DIM*DIM)%DIM][(kk-DIM*DIM)/DIM] = 8'(kk);
`else
               mb[(kk-DIM*DIM)/DIM][(kk-DIM*DIM)%DIM] = 8'(kk);
`endif
            kk++;
         end
      end
      push(0, 0);
      @(negedge clk);
      bus.axiiv = 1'b0;
   endtask

   task automatic pulse_rv();
      @(negedge clk);
      bus.result_valid = 1'b1;
      @(negedge clk);
      bus.result_valid = 1'b0;
   endtask

   task automatic check_issue();
      pair_t e;
      chk("axiov", bus.axiov, 1);
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("row_idx", bus.row_idx, e.i);
         chk("col_idx", bus.col_idx, e.j);
         chk("row_out", bus.row_out, exp_row(e.i));
         chk("col_out", bus.col_out, exp_col(e.j));
      end
   endtask

   initial begin
      logic [255:0] f;
      int cnt;
      bus.axiiv        = 1'b0;
      bus.axiid        = '0;
      bus.result_valid = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_ready", bus.load_ready, 1);
      chk("rst_axiov", bus.axiov, 0);
      chk("rst_done",  bus.done, 0);
      chk("rst_busy",  bus.busy, 0);
      chk("rst_idx",   {bus.row_idx, bus.col_idx}, 0);
      chk("rst_row",   bus.row_out, 0);
      chk("rst_col",   bus.col_out, 0);
      rst = 1'b0;

      load(0);
      check_issue();
      chk("first_ready", bus.load_ready, 0);
      chk("first_busy", bus.busy, 1);
      f = '0;
      for (int l = 0; l < DIM; l++) f[l*8 +: 8] = 8'(l);
      chk("row_formula", bus.row_out, f);
`ifndef B_COL_MAJOR_EN
      for (int l = 0; l < DIM; l++) f[l*8 +: 8] = 8'(l*32);
      chk("col_formula", bus.col_out, f);
`endif
      @(negedge clk);
      chk("axiov_one_cycle", bus.axiov, 0);

      // Hold in WAIT with stray load bytes.
      cnt = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         cnt += int'(bus.axiov);
         bus.axiiv = (c % 10 == 3);
         bus.axiid = 8'hFF;
      end
      bus.axiiv = 1'b0;
      chk("hold_no_axiov", cnt, 0);
      chk("hold_busy", bus.busy, 1);
      push(0, 1);
      pulse_rv();
      check_issue();
`ifndef B_COL_MAJOR_EN
      for (int l = 0; l < DIM; l++) f[l*8 +: 8] = 8'(l*32 + 1);
      chk("col1_formula", bus.col_out, f);
`endif

      for (int p = 2; p < DIM*DIM; p++) begin
         repeat (33) @(negedge clk);
         push(p / DIM, p % DIM);
         pulse_rv();
         check_issue();
         if (p == DIM)
            chk("wrap", {bus.row_idx, bus.col_idx}, {5'd1, 5'd0});
      end
      repeat (33) @(negedge clk);
      pulse_rv();
      chk("done_pulse", bus.done, 1);
      chk("done_axiov", bus.axiov, 0);
      chk("done_busy", bus.busy, 0);
      @(negedge clk);
      chk("done_once", bus.done, 0);
      chk("reload_ready", bus.load_ready, 1);
      chk("sb_drained", sb.size(), 0);

      // result_valid during LOAD is ignored.
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
         pulse_rv();
         cnt += int'(bus.axiov);
      end
      chk("load_rv_axiov", cnt, 0);
      chk("load_rv_ready", bus.load_ready, 1);

      load(3);
      check_issue();
      for (int p = 1; p <= 5; p++) begin
         repeat (5) @(negedge clk);
         push(0, p);
         pulse_rv();
         check_issue();
      end

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_ready", bus.load_ready, 1);
      chk("mid_rst_axiov", bus.axiov, 0);
      chk("mid_rst_idx", {bus.row_idx, bus.col_idx}, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_row", bus.row_out, 0);
      cnt = 0;
      for (int c = 0; c < 3; c++) begin
         repeat (3) @(negedge clk);
         pulse_rv();
         cnt += int'(bus.axiov);
         @(negedge clk);
         cnt += int'(bus.axiov);
      end
      chk("no_issue_before_reload", cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
